// File: rtl/coreuart_sync_fifo_param_if.sv
// Write/read handshake and status bundle between a CoreUART FIFO and its users.
interface coreuart_sync_fifo_param_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 8
);
    logic              CLEAR;
    logic              WE;
    logic [WIDTH-1:0]  DIN;
    logic              RE;
    logic [WIDTH-1:0]  DOUT;
    logic              DVALID;
    logic [ADDR_W:0]   AFULL_LVL;
    logic [ADDR_W:0]   AEMPTY_LVL;
    logic              FULL;
    logic              EMPTY;
    logic              AFULL;
    logic              AEMPTY;
    logic [ADDR_W:0]   COUNT;
    logic              OVERFLOW;
    logic              UNDERFLOW;

    // Producer/consumer side: drives requests and thresholds, observes status.
    modport master (
        output CLEAR, WE, DIN, RE, AFULL_LVL, AEMPTY_LVL,
        input  DOUT, DVALID, FULL, EMPTY, AFULL, AEMPTY, COUNT, OVERFLOW, UNDERFLOW
    );

    // FIFO side.
    modport slave (
        input  CLEAR, WE, DIN, RE, AFULL_LVL, AEMPTY_LVL,
        output DOUT, DVALID, FULL, EMPTY, AFULL, AEMPTY, COUNT, OVERFLOW, UNDERFLOW
    );
endinterface

// File: rtl/coreuart_sync_fifo_param.sv
// Parametrised single-clock FIFO for CoreUART TX/RX buffering.
// Standard mode: DOUT is the synchronous RAM read register (latency 1).
// FWFT mode: RAM read register acts as a prefetch stage feeding the DOUT register,
// so back-to-back pops see no bubble.
module coreuart_sync_fifo_param #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned FWFT   = 0
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    coreuart_sync_fifo_param_if.slave bus
);
    localparam int unsigned CW        = ADDR_W + 1;
    localparam bit          FWFT_MODE = (FWFT != 0);

    logic [WIDTH-1:0]  mem [DEPTH];

    logic [ADDR_W-1:0] wptr_q;
    logic [ADDR_W-1:0] rptr_q;
    logic [CW-1:0]     count_q;
    logic [WIDTH-1:0]  rd_q;
    logic [WIDTH-1:0]  out_q;
    logic              mid_vld_q;
    logic              out_vld_q;
    logic              dvalid_q;
    logic              full_q;
    logic              empty_q;
    logic              afull_q;
    logic              aempty_q;
    logic              ovf_q;
    logic              udf_q;

    logic              flush_c;
    logic              wr_acc_c;
    logic              rd_acc_c;
    logic              ram_rd_c;
    logic              out_load_c;
    logic              mid_vld_nxt_c;
    logic              out_vld_nxt_c;
    logic [CW-1:0]     mem_cnt_c;
    logic [CW-1:0]     count_nxt_c;

    // Accept decisions, prefetch pipeline control and next-state count.
    always_comb begin
        flush_c       = !RESET_N || bus.CLEAR;
        wr_acc_c      = bus.WE && !full_q;
        rd_acc_c      = bus.RE && !empty_q;
        mem_cnt_c     = count_q - CW'(mid_vld_q) - CW'(out_vld_q);
        out_load_c    = 1'b0;
        ram_rd_c      = rd_acc_c;
        mid_vld_nxt_c = 1'b0;
        out_vld_nxt_c = 1'b0;
        if (FWFT_MODE) begin
            // Refill DOUT from the prefetch stage, and the prefetch stage from RAM,
            // whenever the downstream slot is empty or being vacated this cycle.
            out_load_c    = mid_vld_q && (!out_vld_q || rd_acc_c);
            ram_rd_c      = (mem_cnt_c != '0) && (!mid_vld_q || out_load_c);
            mid_vld_nxt_c = ram_rd_c || (mid_vld_q && !out_load_c);
            out_vld_nxt_c = out_load_c || (out_vld_q && !rd_acc_c);
        end
        count_nxt_c = count_q + CW'(wr_acc_c) - CW'(rd_acc_c);
    end

    // Storage array: write port only, contents are never reset.
    always_ff @(posedge CLK) begin
        if (wr_acc_c && !flush_c) begin
            mem[wptr_q] <= bus.DIN;
        end
    end

    // Pointers, count, read/output registers and registered flags; reset and CLEAR flush alike.
    always_ff @(posedge CLK) begin
        if (!RESET_N || bus.CLEAR) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            rd_q      <= '0;
            out_q     <= '0;
            mid_vld_q <= 1'b0;
            out_vld_q <= 1'b0;
            dvalid_q  <= 1'b0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            afull_q   <= (bus.AFULL_LVL == '0);
            // An unsigned threshold is always >= a zero count.
            aempty_q  <= 1'b1;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            if (wr_acc_c) begin
                wptr_q <= wptr_q + ADDR_W'(1);
            end
            if (ram_rd_c) begin
                rptr_q <= rptr_q + ADDR_W'(1);
                rd_q   <= mem[rptr_q];
            end
            if (out_load_c) begin
                out_q <= rd_q;
            end
            count_q   <= count_nxt_c;
            mid_vld_q <= mid_vld_nxt_c;
            out_vld_q <= out_vld_nxt_c;
            dvalid_q  <= FWFT_MODE ? out_vld_nxt_c : rd_acc_c;
            full_q    <= (count_nxt_c == CW'(DEPTH));
            empty_q   <= FWFT_MODE ? !out_vld_nxt_c : (count_nxt_c == '0);
            afull_q   <= (count_nxt_c >= bus.AFULL_LVL);
            aempty_q  <= (count_nxt_c <= bus.AEMPTY_LVL);
            ovf_q     <= ovf_q || (bus.WE && full_q);
            udf_q     <= udf_q || (bus.RE && empty_q);
        end
    end

    assign bus.DOUT      = FWFT_MODE ? out_q : rd_q;
    assign bus.DVALID    = dvalid_q;
    assign bus.FULL      = full_q;
    assign bus.EMPTY     = empty_q;
    assign bus.AFULL     = afull_q;
    assign bus.AEMPTY    = aempty_q;
    assign bus.COUNT     = count_q;
    assign bus.OVERFLOW  = ovf_q;
    assign bus.UNDERFLOW = udf_q;
endmodule
